// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one external asynchronous SRAM between the CPU bus port and the
//   data-logger capture port. Each access runs IDLE -> SETUP -> ACCESS -> DONE:
//   SETUP presents address, byte lanes and write data with CE asserted; ACCESS
//   pulses OE (read) or WE (write) for WAIT_CYCLES clocks; DONE releases the
//   bus for one turnaround cycle and pulses the granted port's ack.
//
//   Build option: define SRAM_ARB_RR_EN for round-robin arbitration between
//   simultaneous requests. Left undefined, the CPU has fixed priority.
//
// Ports
//   clk, reset                       clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata/be         CPU request; held until cpu_ack
//   cpu_rdata, cpu_ack               CPU read data, one-cycle completion pulse
//   log_req/we/addr/wdata/be         logger request; held until log_ack
//   log_rdata, log_ack               logger read data, completion pulse
//   sram_control                     {ce_n, oe_n, we_n, ub_n, lb_n}
//   direcciones                      SRAM word address
//   datos                            SRAM bidirectional data bus
module sram_arbiter #(
   parameter int ADDR_W      = 18,
   parameter int DATA_W      = 16,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic [1:0]        cpu_be,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   input  logic              log_req,
   input  logic              log_we,
   input  logic [ADDR_W-1:0] log_addr,
   input  logic [DATA_W-1:0] log_wdata,
   input  logic [1:0]        log_be,
   output logic [DATA_W-1:0] log_rdata,
   output logic              log_ack,
   output logic [4:0]        sram_control,
   output logic [ADDR_W-1:0] direcciones,
   inout  wire  [DATA_W-1:0] datos
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   // ACCESS lasts cnt load + 1 cycles
   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

   logic [1:0]        state_q, state_d;
   logic              gnt_log_q, gnt_log_d;   // 1 = logger owns the current access
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [1:0]        be_q, be_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] log_rdata_q, log_rdata_d;
   logic              any_req;
   logic              grant_log;
   logic              drive;

   assign any_req = cpu_req | log_req;

`ifdef SRAM_ARB_RR_EN
   logic last_log_q, last_log_d;

   // On a tie the port not served last wins
   assign grant_log  = log_req & (~cpu_req | ~last_log_q);
   assign last_log_d = (state_q == IDLE && any_req) ? grant_log : last_log_q;

   // Reset to "logger" so the CPU wins the first tie
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_log_q <= 1'b1;
      end else begin
         last_log_q <= last_log_d;
      end
   end
`else
   assign grant_log = log_req & ~cpu_req;
`endif

   always_comb begin
      state_d     = state_q;
      gnt_log_d   = gnt_log_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      cnt_d       = cnt_q;
      cpu_rdata_d = cpu_rdata_q;
      log_rdata_d = log_rdata_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               gnt_log_d = grant_log;
               we_d      = grant_log ? log_we    : cpu_we;
               addr_d    = grant_log ? log_addr  : cpu_addr;
               wdata_d   = grant_log ? log_wdata : cpu_wdata;
               be_d      = grant_log ? log_be    : cpu_be;
               state_d   = SETUP;
            end
         end
         SETUP: begin
            cnt_d   = CNT_LOAD;
            state_d = ACCESS;
         end
         ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d = DONE;
               // Final ACCESS edge: OE has been low long enough, sample the bus
               if (!we_q) begin
                  if (gnt_log_q) begin
                     log_rdata_d = datos;
                  end else begin
                     cpu_rdata_d = datos;
                  end
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         gnt_log_q   <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         be_q        <= 2'b00;
         cnt_q       <= 4'd0;
         cpu_rdata_q <= '0;
         log_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         gnt_log_q   <= gnt_log_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         cnt_q       <= cnt_d;
         cpu_rdata_q <= cpu_rdata_d;
         log_rdata_q <= log_rdata_d;
      end
   end

   // Pin controls decode straight from the state register so that reset
   // releases the SRAM in the same cycle it is asserted.
   always_comb begin
      sram_control = 5'b11111;
      drive        = 1'b0;
      case (state_q)
         SETUP: begin
            sram_control = {1'b0, 1'b1, 1'b1, ~be_q[1], ~be_q[0]};
            drive        = we_q;
         end
         ACCESS: begin
            // oe_n follows we so OE and WE can never be low together
            sram_control = {1'b0, we_q, ~we_q, ~be_q[1], ~be_q[0]};
            drive        = we_q;
         end
         default: begin
            sram_control = 5'b11111;
            drive        = 1'b0;
         end
      endcase
   end

   assign datos       = drive ? wdata_q : {DATA_W{1'bz}};
   assign direcciones = addr_q;
   assign cpu_rdata   = cpu_rdata_q;
   assign log_rdata   = log_rdata_q;
   assign cpu_ack     = (state_q == DONE) & ~gnt_log_q;
   assign log_ack     = (state_q == DONE) & gnt_log_q;

endmodule

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
module tb_sram_arbiter;

   typedef struct {
      logic        is_log;
      logic        we;
      logic [17:0] addr;
      logic [15:0] wdata;
      logic [1:0]  be;
      logic [4:0]  exp_setup;
      logic [4:0]  exp_access;
      logic [15:0] exp_data;   // read: expected rdata, write: expected memory word
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   always #5 clk = ~clk;

   // DUT with default WAIT_CYCLES = 1
   logic        cpu_req = 0, cpu_we = 0, log_req = 0, log_we = 0;
   logic [17:0] cpu_addr = '0, log_addr = '0;
   logic [15:0] cpu_wdata = '0, log_wdata = '0;
   logic [1:0]  cpu_be = '0, log_be = '0;
   logic [15:0] cpu_rdata, log_rdata;
   logic        cpu_ack, log_ack;
   logic [4:0]  ctrl;
   logic [17:0] dir;
   wire  [15:0] datos;

   // DUT with WAIT_CYCLES = 3
   logic        cpu_req3 = 0;
   logic [17:0] cpu_addr3 = '0;
   logic        tie0 = 1'b0;
   logic [17:0] tie_addr = '0;
   logic [15:0] tie_data = '0;
   logic [1:0]  tie_be = '0;
   logic [15:0] cpu_rdata3, log_rdata3;
   logic        cpu_ack3, log_ack3;
   logic [4:0]  ctrl3;
   logic [17:0] dir3;
   wire  [15:0] datos3;

   sram_arbiter dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_be(cpu_be), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .log_req(log_req), .log_we(log_we), .log_addr(log_addr), .log_wdata(log_wdata),
      .log_be(log_be), .log_rdata(log_rdata), .log_ack(log_ack),
      .sram_control(ctrl), .direcciones(dir), .datos(datos)
   );

   sram_arbiter #(.WAIT_CYCLES(3)) dut3 (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req3), .cpu_we(tie0), .cpu_addr(cpu_addr3), .cpu_wdata(tie_data),
      .cpu_be(2'b11), .cpu_rdata(cpu_rdata3), .cpu_ack(cpu_ack3),
      .log_req(tie0), .log_we(tie0), .log_addr(tie_addr), .log_wdata(tie_data),
      .log_be(tie_be), .log_rdata(log_rdata3), .log_ack(log_ack3),
      .sram_control(ctrl3), .direcciones(dir3), .datos(datos3)
   );

   // SRAM model for dut: drives on CE&OE with WE high, writes byte lanes while CE&WE low
   logic [15:0] mem [0:255];
   logic        probe_en = 1'b0;
   assign datos = (!ctrl[4] && !ctrl[3] && ctrl[2]) ? mem[dir[7:0]] : 16'bz;
   // Known pattern put on the bus while the DUT must be released
   assign datos = probe_en ? 16'h0F0F : 16'bz;

   always @(posedge clk) begin
      if (!ctrl[4] && !ctrl[2]) begin
         if (!ctrl[1]) mem[dir[7:0]][15:8] <= datos[15:8];
         if (!ctrl[0]) mem[dir[7:0]][7:0]  <= datos[7:0];
      end
   end

   // Read-only pattern source for dut3
   assign datos3 = (!ctrl3[4] && !ctrl3[3]) ? (16'h5A5A ^ dir3[15:0]) : 16'bz;

   int n_vec = 0;
   int n_fail = 0;
   int overlap_cnt = 0;

   always @(negedge clk) begin
      if ((!ctrl[3] && !ctrl[2]) || (!ctrl3[3] && !ctrl3[2])) overlap_cnt <= overlap_cnt + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk_bus_free(input string name);
      probe_en = 1'b1;
      #1;
      chk(name, 32'(datos), 32'h0F0F);
      probe_en = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      logic [15:0] other;
      @(negedge clk);
      if (v.is_log) begin
         log_we = v.we; log_addr = v.addr; log_wdata = v.wdata; log_be = v.be; log_req = 1'b1;
         other = cpu_rdata;
      end else begin
         cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_be = v.be; cpu_req = 1'b1;
         other = log_rdata;
      end
      @(posedge clk); #1;   // SETUP
      chk({tag, "_setup_ctrl"}, 32'(ctrl), 32'(v.exp_setup));
      chk({tag, "_setup_addr"}, 32'(dir), 32'(v.addr));
      chk({tag, "_setup_ack"}, 32'({cpu_ack, log_ack}), 32'h0);
      @(posedge clk); #1;   // ACCESS
      chk({tag, "_access_ctrl"}, 32'(ctrl), 32'(v.exp_access));
      if (v.we) chk({tag, "_access_datos"}, 32'(datos), 32'(v.wdata));
      chk({tag, "_access_ack"}, 32'({cpu_ack, log_ack}), 32'h0);
      @(posedge clk); #1;   // DONE
      chk({tag, "_done_ack"}, 32'({cpu_ack, log_ack}), v.is_log ? 32'h1 : 32'h2);
      chk({tag, "_done_ctrl"}, 32'(ctrl), 32'h1F);
      chk_bus_free({tag, "_done_datos_z"});
      if (!v.we) chk({tag, "_rdata"}, 32'(v.is_log ? log_rdata : cpu_rdata), 32'(v.exp_data));
      chk({tag, "_other_rdata"}, 32'(v.is_log ? cpu_rdata : log_rdata), 32'(other));
      @(negedge clk);
      cpu_req = 1'b0;
      log_req = 1'b0;
      if (v.we) chk({tag, "_mem"}, 32'(mem[v.addr[7:0]]), 32'(v.exp_data));
   endtask

   vec_t vecs [9];
   vec_t reissue;
   int   order [4];
   int   exp_order [4];
   int   n_got;
   int   ack_edge;
   int   oe_cnt;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[8'h20] <= 16'hCAFE;

      //          log we addr        wdata     be     setup     access    data
      vecs[0] = '{1'b0, 1'b1, 18'h00012, 16'hBEEF, 2'b11, 5'b01100, 5'b01000, 16'hBEEF};
      vecs[1] = '{1'b0, 1'b0, 18'h00012, 16'h0000, 2'b11, 5'b01100, 5'b00100, 16'hBEEF};
      vecs[2] = '{1'b1, 1'b1, 18'h00020, 16'h1234, 2'b01, 5'b01110, 5'b01010, 16'hCA34};
      vecs[3] = '{1'b1, 1'b0, 18'h00020, 16'h0000, 2'b11, 5'b01100, 5'b00100, 16'hCA34};
      vecs[4] = '{1'b0, 1'b1, 18'h00005, 16'h5A5A, 2'b10, 5'b01101, 5'b01001, 16'h5A00};
      vecs[5] = '{1'b0, 1'b0, 18'h00005, 16'h0000, 2'b00, 5'b01111, 5'b00111, 16'h5A00};
      vecs[6] = '{1'b1, 1'b1, 18'h00030, 16'hFFFF, 2'b00, 5'b01111, 5'b01011, 16'h0000};
      vecs[7] = '{1'b0, 1'b1, 18'h3FFFF, 16'h1357, 2'b11, 5'b01100, 5'b01000, 16'h1357};
      vecs[8] = '{1'b1, 1'b0, 18'h3FFFF, 16'h0000, 2'b11, 5'b01100, 5'b00100, 16'h1357};
      reissue = '{1'b0, 1'b1, 18'h00040, 16'h7777, 2'b11, 5'b01100, 5'b01000, 16'h7777};

      // Reset state
      #12;
      chk("rst_ctrl", 32'(ctrl), 32'h1F);
      chk("rst_addr", 32'(dir), 32'h0);
      chk("rst_ack", 32'({cpu_ack, log_ack}), 32'h0);
      chk("rst_rdata", 32'({cpu_rdata, log_rdata}), 32'h0);
      chk_bus_free("rst_datos_z");
      @(negedge clk);
      reset = 1'b0;

      // WAIT_CYCLES = 3: edge 1 samples, ack after edge 5, OE low for 3 cycles
      @(negedge clk);
      cpu_addr3 = 18'h00100;
      cpu_req3  = 1'b1;
      ack_edge  = 0;
      oe_cnt    = 0;
      for (int e = 1; e <= 12; e++) begin
         @(posedge clk); #1;
         if (!ctrl3[3]) oe_cnt++;
         if (cpu_ack3 && ack_edge == 0) begin
            ack_edge = e;
            chk("w3_rdata", 32'(cpu_rdata3), 32'h5B5A);
            cpu_req3 = 1'b0;
         end
      end
      chk("w3_ack_edge", 32'(ack_edge), 32'd5);
      chk("w3_oe_cycles", 32'(oe_cnt), 32'd3);

      for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // Reset in the middle of a write ACCESS
      @(negedge clk);
      cpu_we = 1'b1; cpu_addr = 18'h00040; cpu_wdata = 16'h7777; cpu_be = 2'b11; cpu_req = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      chk("abort_access_ctrl", 32'(ctrl), 32'h08);
      reset = 1'b1;
      #1;
      chk("abort_ctrl", 32'(ctrl), 32'h1F);
      chk("abort_ack", 32'({cpu_ack, log_ack}), 32'h0);
      chk_bus_free("abort_datos_z");
      @(posedge clk); #1;
      chk("abort_ack_later", 32'({cpu_ack, log_ack}), 32'h0);
      @(negedge clk);
      cpu_req = 1'b0;
      reset   = 1'b0;
      chk("abort_mem", 32'(mem[8'h40]), 32'h0);

      // Both ports requesting back to back
`ifdef SRAM_ARB_RR_EN
      exp_order = '{0, 1, 0, 1};
`else
      exp_order = '{0, 0, 0, 0};
`endif
      @(negedge clk);
      cpu_we = 1'b0; cpu_addr = 18'h00012; cpu_be = 2'b11; cpu_req = 1'b1;
      log_we = 1'b0; log_addr = 18'h00020; log_be = 2'b11; log_req = 1'b1;
      n_got = 0;
      for (int c = 0; c < 40 && n_got < 4; c++) begin
         @(posedge clk); #1;
         if (cpu_ack) begin
            order[n_got] = 0;
            n_got++;
            chk("tie_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);
         end else if (log_ack) begin
            order[n_got] = 1;
            n_got++;
            chk("tie_log_rdata", 32'(log_rdata), 32'hCA34);
         end
      end
      @(negedge clk);
      cpu_req = 1'b0;
      log_req = 1'b0;
      chk("tie_count", 32'(n_got), 32'd4);
      for (int k = 0; k < 4; k++) begin
         if (k < n_got) chk($sformatf("tie_order%0d", k), 32'(order[k]), 32'(exp_order[k]));
      end
      repeat (2) @(negedge clk);

      run_vec(reissue, "reissue");

      chk("no_oe_we_overlap", 32'(overlap_cnt), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1);
   end

endmodule
